// File: rtl/dct16_odd_mac_if.sv
// Handshake bundle for the odd-half DCT16 MAC: butterfly differences in,
// one odd coefficient per transfer out.
interface dct16_odd_mac_if;
    logic               i_valid;
    logic               i_ready;
    logic signed [27:0] i_d0;
    logic signed [27:0] i_d1;
    logic signed [27:0] i_d2;
    logic signed [27:0] i_d3;
    logic signed [27:0] i_d4;
    logic signed [27:0] i_d5;
    logic signed [27:0] i_d6;
    logic signed [27:0] i_d7;
    logic               o_valid;
    logic               o_ready;
    logic signed [36:0] o_coef;
    logic [2:0]         o_idx;
    logic               o_last;

    modport slave (
        input  i_valid, i_d0, i_d1, i_d2, i_d3,
        input  i_d4, i_d5, i_d6, i_d7, o_ready,
        output i_ready, o_valid, o_coef, o_idx, o_last
    );

    modport master (
        output i_valid, i_d0, i_d1, i_d2, i_d3,
        output i_d4, i_d5, i_d6, i_d7, o_ready,
        input  i_ready, o_valid, o_coef, o_idx, o_last
    );
endinterface

// File: rtl/dct16_odd_mac.sv
// Odd half of the 16-point forward DCT: one exact odd coefficient per
// cycle from eight latched butterfly differences.
module dct16_odd_mac (
    input logic            clk,
    input logic            rst_n,
    dct16_odd_mac_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic signed [7:0] C [8][8] = '{
        '{ 8'sd90,  8'sd87,  8'sd80,  8'sd70,
           8'sd57,  8'sd43,  8'sd25,  8'sd9  },
        '{ 8'sd87,  8'sd57,  8'sd9,  -8'sd43,
          -8'sd80, -8'sd90, -8'sd70, -8'sd25 },
        '{ 8'sd80,  8'sd9,  -8'sd70, -8'sd87,
          -8'sd25,  8'sd57,  8'sd90,  8'sd43 },
        '{ 8'sd70, -8'sd43, -8'sd87,  8'sd9,
           8'sd90,  8'sd25, -8'sd80, -8'sd57 },
        '{ 8'sd57, -8'sd80, -8'sd25,  8'sd90,
          -8'sd9,  -8'sd87,  8'sd43,  8'sd70 },
        '{ 8'sd43, -8'sd90,  8'sd57,  8'sd25,
          -8'sd87,  8'sd70,  8'sd9,  -8'sd80 },
        '{ 8'sd25, -8'sd70,  8'sd90, -8'sd80,
           8'sd43,  8'sd9,  -8'sd57,  8'sd87 },
        '{ 8'sd9,  -8'sd25,  8'sd43, -8'sd57,
           8'sd70, -8'sd80,  8'sd87, -8'sd90 }
    };

    logic [0:0]         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic signed [27:0] d_q [8];
    logic signed [27:0] d_d [8];
    logic signed [27:0] din [8];
    logic               valid_q, valid_d;
    logic signed [36:0] coef_q, coef_d;
    logic [2:0]         idx_q, idx_d;
    logic               last_q, last_d;
    logic signed [36:0] row_sum;
    logic               load;

    assign din[0] = bus.i_d0;
    assign din[1] = bus.i_d1;
    assign din[2] = bus.i_d2;
    assign din[3] = bus.i_d3;
    assign din[4] = bus.i_d4;
    assign din[5] = bus.i_d5;
    assign din[6] = bus.i_d6;
    assign din[7] = bus.i_d7;

    // Row sums are bounded by 461 * 2^27, so 37 bits never overflow.
    always_comb begin
        row_sum = '0;
        for (int n = 0; n < 8; n++) begin
            row_sum = row_sum + 37'(d_q[n]) * 37'(C[cnt_q][n]);
        end
    end

    assign load = (state_q == S_CALC) && (!valid_q || bus.o_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        valid_d = valid_q;
        coef_d  = coef_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (valid_q && bus.o_ready) begin
            valid_d = 1'b0;
        end
        if (state_q == S_IDLE) begin
            if (bus.i_valid) begin
                d_d     = din;
                cnt_d   = 3'd0;
                state_d = S_CALC;
            end
        end else if (load) begin
            coef_d  = row_sum;
            idx_d   = cnt_q;
            last_d  = (cnt_q == 3'd7);
            valid_d = 1'b1;
            if (cnt_q == 3'd7) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            coef_q  <= '0;
            idx_q   <= 3'd0;
            last_q  <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                d_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            coef_q  <= coef_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            d_q     <= d_d;
        end
    end

    assign bus.i_ready = (state_q == S_IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_coef  = coef_q;
    assign bus.o_idx   = idx_q;
    assign bus.o_last  = last_q;

endmodule

// File: tb/tb_dct16_odd_mac.sv
// Directed bench for dct16_odd_mac: impulse, row sums, extremes,
// backpressure, back-to-back vectors and mid-run reset.
module tb_dct16_odd_mac;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dct16_odd_mac_if bus ();

    dct16_odd_mac dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int C_tb [8][8] = '{
        '{90, 87, 80, 70, 57, 43, 25, 9},
        '{87, 57, 9, -43, -80, -90, -70, -25},
        '{80, 9, -70, -87, -25, 57, 90, 43},
        '{70, -43, -87, 9, 90, 25, -80, -57},
        '{57, -80, -25, 90, -9, -87, 43, 70},
        '{43, -90, 57, 25, -87, 70, 9, -80},
        '{25, -70, 90, -80, 43, 9, -57, 87},
        '{9, -25, 43, -57, 70, -80, 87, -90}
    };

    longint rs [8] = '{461, -155, 97, -73, 59, -53, 47, -43};

    logic signed [27:0] dv [8];
    longint exp_r [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_row(input int k);
        longint s = 0;
        for (int n = 0; n < 8; n++) begin
            s += longint'(C_tb[k][n]) * longint'(dv[n]);
        end
        return s;
    endfunction

    task automatic apply;
        bus.i_d0 = dv[0];
        bus.i_d1 = dv[1];
        bus.i_d2 = dv[2];
        bus.i_d3 = dv[3];
        bus.i_d4 = dv[4];
        bus.i_d5 = dv[5];
        bus.i_d6 = dv[6];
        bus.i_d7 = dv[7];
    endtask

    task automatic accept(input string tag);
        apply();
        bus.i_valid = 1'b1;
        chk({tag, "_irdy"}, bus.i_ready, 1);
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic expect_rows(input string tag);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("%s_v%0d", tag, k), bus.o_valid, 1);
            chk($sformatf("%s_i%0d", tag, k), bus.o_idx, k);
            chk($sformatf("%s_l%0d", tag, k), bus.o_last, (k == 7));
            chk($sformatf("%s_c%0d", tag, k), bus.o_coef, exp_r[k]);
        end
    endtask

    task automatic set_dv(input int v);
        for (int n = 0; n < 8; n++) dv[n] = 28'(v);
    endtask

    initial begin
        int got;
        int stalled;
        logic signed [36:0] pc;
        logic [2:0] pi;
        int pat [6] = '{1, 0, 0, 1, 1, 0};

        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        set_dv(0);
        apply();

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_coef", bus.o_coef, 0);
        chk("rst_idx", bus.o_idx, 0);
        chk("rst_last", bus.o_last, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_irdy", bus.i_ready, 1);

        set_dv(0);
        dv[0] = 28'sd1;
        for (int k = 0; k < 8; k++) exp_r[k] = C_tb[k][0];
        accept("imp");
        expect_rows("imp");
        chk("imp_idle", bus.i_ready, 1);

        set_dv(1);
        for (int k = 0; k < 8; k++) exp_r[k] = rs[k];
        accept("ones");
        expect_rows("ones");
        tick();
        chk("ones_done", bus.o_valid, 0);

        for (int n = 0; n < 8; n++) dv[n] = 28'sh8000000;
        for (int k = 0; k < 8; k++) exp_r[k] = -64'sd134217728 * rs[k];
        exp_r[0] = -64'sd61874372608;
        accept("ext");
        expect_rows("ext");

        for (int n = 0; n < 8; n++) begin
            dv[n] = (C_tb[1][n] > 0) ? 28'sd134217727 : -28'sd134217727;
        end
        for (int k = 0; k < 8; k++) exp_r[k] = ref_row(k);
        exp_r[1] = 64'sd61874372147;
        accept("alt");
        expect_rows("alt");

        set_dv(1);
        for (int k = 0; k < 8; k++) exp_r[k] = rs[k];
        accept("bp");
        got = 0;
        stalled = 0;
        pc = '0;
        pi = '0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            bus.o_ready = pat[c % 6][0];
            #2;
            if (stalled != 0) begin
                chk("bp_hold_c", bus.o_coef, pc);
                chk("bp_hold_i", bus.o_idx, pi);
            end
            if (!(bus.o_valid && bus.o_last)) begin
                chk("bp_irdy", bus.i_ready, 0);
            end
            if (bus.o_valid) begin
                if (bus.o_ready) begin
                    chk($sformatf("bp_i%0d", got), bus.o_idx, got);
                    chk($sformatf("bp_c%0d", got), bus.o_coef, exp_r[got]);
                    chk($sformatf("bp_l%0d", got), bus.o_last, (got == 7));
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pc = bus.o_coef;
                    pi = bus.o_idx;
                end
            end else begin
                stalled = 0;
            end
            tick();
        end
        chk("bp_count", got, 8);
        bus.o_ready = 1'b1;
        tick();

        set_dv(0);
        dv[0] = 28'sd1;
        for (int k = 0; k < 8; k++) exp_r[k] = C_tb[k][0];
        apply();
        bus.i_valid = 1'b1;
        chk("b2b_irdy", bus.i_ready, 1);
        tick();
        set_dv(0);
        dv[1] = 28'sd1;
        apply();
        expect_rows("b2b_a");
        chk("b2b_idle", bus.i_ready, 1);
        tick();
        bus.i_valid = 1'b0;
        chk("b2b_gap", bus.o_valid, 0);
        for (int k = 0; k < 8; k++) exp_r[k] = C_tb[k][1];
        expect_rows("b2b_b");

        set_dv(0);
        dv[0] = 28'sd1;
        for (int k = 0; k < 8; k++) exp_r[k] = C_tb[k][0];
        accept("mr");
        tick();
        tick();
        tick();
        chk("mr_row2", bus.o_idx, 2);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", bus.o_valid, 0);
        chk("mr_coef", bus.o_coef, 0);
        chk("mr_idx", bus.o_idx, 0);
        chk("mr_last", bus.o_last, 0);
        chk("mr_irdy", bus.i_ready, 1);
        rst_n = 1'b1;
        accept("mr2");
        expect_rows("mr2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
